regfile_reader: RTL and testbench

- Read-side initiator for the 8x4 register file: walks every address in order and streams each entry out over a valid/ready interface.
- Drives the register file's address input and samples its combinational read data.
- Keeps a running sum of streamed entries and pulses done at the end of a sweep.
- Sits between the register file and downstream consumers such as display or UART formatters; it is the read-side counterpart of the load/din write path.

---
 rtl/regfile_reader_pkg.sv | 9 +
 rtl/regfile_reader_if.sv | 20 ++
 rtl/regfile_reader.sv | 88 ++++++++
 tb/tb_regfile_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// regfile_pkg: shared register-file geometry, entry/address types and reader FSM states.
package regfile_pkg;
   localparam int REGFILE_DATA_W = 4;
   localparam int REGFILE_ADDR_W = 3;
   localparam int REGFILE_DEPTH = 8;
   typedef logic [REGFILE_DATA_W-1:0] rf_data_t;
   typedef logic [REGFILE_ADDR_W-1:0] rf_addr_t;
   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} reader_state_t;
endpackage

// File: rtl/regfile_reader_if.sv
// regfile_reader_if: register-file read port plus the downstream valid/ready entry stream.
interface regfile_reader_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic out_valid;
   logic out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   modport master (
      output rd_addr, out_valid, out_data, out_addr,
      input rd_data, out_ready
   );
   modport slave (
      input rd_addr, out_valid, out_data, out_addr,
      output rd_data, out_ready
   );
endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: sweeps the register file in address order, streams entries over valid/ready, sums them.
// Define REGFILE_READER_SKIP_ZERO_EN to skip zero-valued entries instead of presenting them.
module regfile_reader
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W,
   parameter int DEPTH = REGFILE_DEPTH,
   parameter int SUM_W = DATA_W + ADDR_W
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic [SUM_W-1:0] sum,
   regfile_reader_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   reader_state_t state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d, rd_addr_q, rd_addr_d, out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic last;
   assign last = index_q == LAST;
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      rd_addr_d = rd_addr_q;
      out_data_d = out_data_q;
      out_addr_d = out_addr_q;
      sum_d = sum_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = FETCH;
            index_d = '0;
            rd_addr_d = '0;
            sum_d = '0;
         end
         FETCH: begin
            state_d = PRESENT;
            out_data_d = bus.rd_data;
            out_addr_d = index_q;
`ifdef REGFILE_READER_SKIP_ZERO_EN
            if (bus.rd_data == '0) begin
               state_d = last ? DONE : FETCH;
               out_data_d = out_data_q;
               out_addr_d = out_addr_q;
               index_d = last ? index_q : index_q + 1'b1;
               rd_addr_d = last ? rd_addr_q : index_q + 1'b1;
            end
`endif
         end
         PRESENT: if (bus.out_ready) begin
            // the last entry holds its index so rd_addr never wraps past DEPTH-1
            state_d = last ? DONE : FETCH;
            sum_d = sum_q + SUM_W'(out_data_q);
            index_d = last ? index_q : index_q + 1'b1;
            rd_addr_d = last ? rd_addr_q : index_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         index_q <= '0;
         rd_addr_q <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
         sum_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         rd_addr_q <= rd_addr_d;
         out_data_q <= out_data_d;
         out_addr_q <= out_addr_d;
         sum_q <= sum_d;
      end
   end
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign sum = sum_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.out_valid = state_q == PRESENT;
   assign bus.out_data = out_data_q;
   assign bus.out_addr = out_addr_q;
endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: randomized and directed sweeps scored against a queue-based model of the expected stream.
module tb_regfile_reader;
`ifdef REGFILE_READER_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   typedef struct {
      int addr;
      int data;
   } entry_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done;
   logic [6:0] sum;
   logic [3:0] rf [8];
   regfile_reader_if #(.DATA_W(4), .ADDR_W(3)) bus ();
   regfile_reader dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .busy(busy),
      .done(done),
      .sum(sum),
      .bus(bus)
   );
   assign bus.rd_data = rf[bus.rd_addr];
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int last_lat = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   int m_sum = 0;
   bit m_active = 1'b0;
   bit prev_xfer = 1'b0;
   bit prev_last = 1'b0;
   bit accept, xfer;
   entry_t q[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   // Scoreboard: expected stream is the file snapshot taken when a start is accepted.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 32'(bus.out_valid), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_sum", 32'(sum), 0);
         q.delete();
         m_active = 1'b0;
         m_sum = 0;
         prev_xfer = 1'b0;
         prev_last = 1'b0;
      end else begin
         chk("busy", 32'(busy), 32'(m_active));
         if (prev_xfer) chk("valid_gap", 32'(bus.out_valid), 0);
         if (bus.out_valid) begin
            if (q.size() == 0) chk("extra_entry", 32'(bus.out_valid), 0);
            else begin
               chk("out_addr", 32'(bus.out_addr), 32'(q[0].addr));
               chk("out_data", 32'(bus.out_data), 32'(q[0].data));
               chk("rd_addr", 32'(bus.rd_addr), 32'(q[0].addr));
            end
         end
`ifndef REGFILE_READER_SKIP_ZERO_EN
         chk("done_timing", 32'(done), 32'(prev_last));
`endif
         if (done) begin
            chk("done_in_sweep", 32'(m_active), 1);
            chk("done_q_empty", 32'(q.size()), 0);
            chk("done_sum", 32'(sum), 32'(m_sum & 127));
            done_cnt++;
            last_lat = cyc - start_cyc;
         end
         xfer = bus.out_valid && bus.out_ready && q.size() > 0;
         accept = start && !m_active;
         prev_xfer = xfer || accept;
         prev_last = xfer && q.size() == 1;
         if (xfer) begin
            m_sum += q[0].data;
            void'(q.pop_front());
            xfer_cnt++;
         end
         if (done) m_active = 1'b0;
         if (accept) begin
            m_active = 1'b1;
            m_sum = 0;
            start_cyc = cyc;
            q.delete();
            for (int i = 0; i < 8; i++)
               if (!SKIP || rf[i] != 0) q.push_back('{addr: i, data: int'(rf[i])});
         end
      end
   end
   task automatic begin_sweep();
      xfer_cnt = 0;
      done_cnt = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic end_sweep(input string tag, input int exp_lat, input int exp_sum, input int exp_x);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk({tag, "_done_seen"}, 32'(done), 1);
      chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      @(posedge clk);
      #1;
      chk({tag, "_latency"}, 32'(last_lat), 32'(exp_lat));
      chk({tag, "_xfers"}, 32'(xfer_cnt), 32'(exp_x));
      chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
   endtask
   task automatic wait_addr(input int a);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_addr == 3'(a)) break;
      end
      chk("wait_entry_valid", 32'(bus.out_valid), 1);
   endtask
   initial begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) rf[i] = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_rd_addr", 32'(bus.rd_addr), 0);
      chk("reset_out_data", 32'(bus.out_data), 0);
      chk("reset_out_addr", 32'(bus.out_addr), 0);
      chk("reset_done", 32'(done), 0);
      bus.out_ready = 1'b1;
      begin_sweep();
      end_sweep("cleared", SKIP ? 9 : 17, 0, SKIP ? 0 : 8);
      for (int i = 0; i < 8; i++) rf[i] = 4'(i + 1);
      begin_sweep();
      end_sweep("ramp", 17, 36, 8);
      begin_sweep();
      wait_addr(2);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 1);
         chk("bp_data", 32'(bus.out_data), 4);
         chk("bp_addr", 32'(bus.out_addr), 3);
         chk("bp_rd_addr", 32'(bus.rd_addr), 3);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      end_sweep("backpressure", 22, 36, 8);
      begin_sweep();
      wait_addr(4);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      wait_addr(7);
      @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      chk("restart_done", 32'(done), 1);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("restart_idle", 32'(busy), 0);
      end
      chk("restart_xfers", 32'(xfer_cnt), 8);
      chk("restart_done_cnt", 32'(done_cnt), 1);
      begin_sweep();
      wait_addr(4);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", 32'(bus.out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sum", 32'(sum), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_no_done", 32'(done_cnt), 0);
      begin_sweep();
      end_sweep("after_abort", 17, 36, 8);
      for (int i = 0; i < 8; i++) rf[i] = 4'h0;
      rf[2] = 4'h5;
      rf[6] = 4'hA;
      begin_sweep();
      end_sweep("sparse", SKIP ? 11 : 17, 15, SKIP ? 2 : 8);
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk);
         #1;
         bus.out_ready = $urandom_range(3) != 0;
         start = 1'b0;
         if (!busy && $urandom_range(1) == 1)
            rf[$urandom_range(7)] = $urandom_range(2) == 0 ? 4'h0 : 4'($urandom_range(15));
         else start = $urandom_range(5) == 0;
      end
      #1 start = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("final_idle", 32'(busy), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
